elastic_pipeline: RTL and testbench

Parametrised successor to the fixed-depth address/ID pipeline. It carries {address, id} tokens through DEPTH register stages under a valid/stall handshake. Each stage has a main register and a skid register, so every stall output is registered, with no combinational stall path through the chain, and the pipeline sustains one token per cycle. It adds a synchronous flush and a live occupancy count. It sits between request issue and the downstream memory/arbiter path.

---
 rtl/elastic_pipeline.sv | 109 ++++++++++
 tb/tb_elastic_pipeline.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline.sv
// Elastic {address, id} pipeline: DEPTH stages, each with a main and a skid register,
// so the upstream stall is a flop and the chain holds one token per cycle under backpressure.
module elastic_pipeline #(
  parameter  int ADDRESS_WIDTH = 32,
  parameter  int ID_WIDTH      = 4,
  parameter  int DEPTH         = 4,
  localparam int OCC_WIDTH     = $clog2(2*DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic                     in_valid,
  output logic                     out_stall,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_valid,
  input  logic                     in_stall,
  output logic [OCC_WIDTH-1:0]     occupancy
);

  localparam int DW = ADDRESS_WIDTH + ID_WIDTH;

  logic          r_main_v [DEPTH];
  logic [DW-1:0] r_main_d [DEPTH];
  logic          r_skid_v [DEPTH];
  logic [DW-1:0] r_skid_d [DEPTH];
  logic [OCC_WIDTH-1:0] r_occupancy;

  logic          w_in_v      [DEPTH];
  logic [DW-1:0] w_in_d      [DEPTH];
  logic          w_stall_nx  [DEPTH];
  logic          w_acc_in    [DEPTH];
  logic          w_main_free [DEPTH];
  logic          w_in_xfer;
  logic          w_out_xfer;

  // Stage k is fed by stage k-1's main register and stalled by stage k+1's skid flag.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_in_v[g] = in_valid;
      assign w_in_d[g] = {in_address, in_id};
    end else begin : g_body
      assign w_in_v[g] = r_main_v[g-1];
      assign w_in_d[g] = r_main_d[g-1];
    end

    if (g == DEPTH-1) begin : g_tail
      assign w_stall_nx[g] = in_stall;
    end else begin : g_link
      assign w_stall_nx[g] = r_skid_v[g+1];
    end

    assign w_acc_in[g]    = w_in_v[g] & ~r_skid_v[g];
    assign w_main_free[g] = ~r_main_v[g] | ~w_stall_nx[g];
  end

  assign w_in_xfer  = in_valid & ~r_skid_v[0];
  assign w_out_xfer = r_main_v[DEPTH-1] & ~in_stall;

  // NOTE: payload registers are reset as well, so outputs are deterministic after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_main_v[k] <= 1'b0;
        r_main_d[k] <= '0;
        r_skid_v[k] <= 1'b0;
        r_skid_d[k] <= '0;
      end
      r_occupancy <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          r_main_v[k] <= 1'b0;
          r_skid_v[k] <= 1'b0;
        end else if (w_main_free[k]) begin
          // A parked skid token always has priority so ordering stays FIFO.
          if (r_skid_v[k]) begin
            r_main_v[k] <= 1'b1;
            r_main_d[k] <= r_skid_d[k];
          end else if (w_acc_in[k]) begin
            r_main_v[k] <= 1'b1;
            r_main_d[k] <= w_in_d[k];
          end else begin
            r_main_v[k] <= 1'b0;
          end
          r_skid_v[k] <= 1'b0;
        end else if (w_acc_in[k]) begin
          r_skid_v[k] <= 1'b1;
          r_skid_d[k] <= w_in_d[k];
        end
      end

      if (flush) begin
        r_occupancy <= '0;
      end else begin
        r_occupancy <= r_occupancy + OCC_WIDTH'(w_in_xfer) - OCC_WIDTH'(w_out_xfer);
      end
    end
  end

  assign out_stall   = r_skid_v[0];
  assign out_valid   = r_main_v[DEPTH-1];
  assign out_address = r_main_d[DEPTH-1][DW-1:ID_WIDTH];
  assign out_id      = r_main_d[DEPTH-1][ID_WIDTH-1:0];
  assign occupancy   = r_occupancy;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Scoreboard bench for elastic_pipeline: a DEPTH=4 instance for the main scenarios
// and a DEPTH=1 instance for the minimum-depth case.
module tb_elastic_pipeline;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    int          due;   // cycle the token must leave, or -1 when only order matters
  } tok_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  tok_t q_a[$];
  tok_t q_b[$];

  logic        a_flush, a_in_valid, a_out_stall, a_out_valid, a_in_stall;
  logic [31:0] a_addr, a_out_addr;
  logic [3:0]  a_id, a_out_id;
  logic [3:0]  a_occ;

  logic        b_flush, b_in_valid, b_out_stall, b_out_valid, b_in_stall;
  logic [31:0] b_addr, b_out_addr;
  logic [3:0]  b_id, b_out_id;
  logic [1:0]  b_occ;

  elastic_pipeline #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .DEPTH(4)) u_dut_a (
    .clk(clk), .reset(rst_n), .flush(a_flush),
    .in_address(a_addr), .in_id(a_id), .in_valid(a_in_valid),
    .out_stall(a_out_stall), .out_address(a_out_addr), .out_id(a_out_id),
    .out_valid(a_out_valid), .in_stall(a_in_stall), .occupancy(a_occ)
  );

  elastic_pipeline #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .DEPTH(1)) u_dut_b (
    .clk(clk), .reset(rst_n), .flush(b_flush),
    .in_address(b_addr), .in_id(b_id), .in_valid(b_in_valid),
    .out_stall(b_out_stall), .out_address(b_out_addr), .out_id(b_out_id),
    .out_valid(b_out_valid), .in_stall(b_in_stall), .occupancy(b_occ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one token to instance A for one cycle; accept it unless a stall is expected.
  task automatic drive_a(input logic [3:0] id, input logic stall, input logic exp_stall,
                         input int due, output logic acc);
    tok_t t;
    a_in_valid = 1'b1;
    a_id       = id;
    a_addr     = 32'h1000 + 32'(id);
    a_in_stall = stall;
    @(negedge clk);
    check("a_out_stall", {63'd0, a_out_stall}, {63'd0, exp_stall});
    acc = !exp_stall;
    if (acc) begin
      t.addr = 32'h1000 + 32'(id);
      t.id   = id;
      t.due  = due;
      q_a.push_back(t);
    end
    tick();
  endtask

  // Output monitors: a transfer happens on the coming edge when valid and not stalled.
  always @(negedge clk) begin
    tok_t t;
    if (rst_n && a_out_valid && !a_in_stall) begin
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_out: got id %0h, required no output", a_out_id);
      end else begin
        t = q_a.pop_front();
        check("a_out_id", {60'd0, a_out_id}, {60'd0, t.id});
        check("a_out_address", {32'd0, a_out_addr}, {32'd0, t.addr});
        if (t.due >= 0) check("a_out_cycle", 64'(cyc), 64'(t.due));
      end
    end
  end

  always @(negedge clk) begin
    tok_t t;
    if (rst_n && b_out_valid && !b_in_stall) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_out: got id %0h, required no output", b_out_id);
      end else begin
        t = q_b.pop_front();
        check("b_out_id", {60'd0, b_out_id}, {60'd0, t.id});
        check("b_out_address", {32'd0, b_out_addr}, {32'd0, t.addr});
        if (t.due >= 0) check("b_out_cycle", 64'(cyc), 64'(t.due));
      end
    end
  end

  initial begin
    #200000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   accepted;
    int   s, t_st, r, k;
    tok_t tb;

    rst_n = 1'b0;
    {a_flush, a_in_valid, a_in_stall, a_addr, a_id} = '0;
    {b_flush, b_in_valid, b_in_stall, b_addr, b_id} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_a_out_stall", {63'd0, a_out_stall}, 64'd0);
    check("rst_a_occupancy", {60'd0, a_occ}, 64'd0);
    check("rst_b_occupancy", {62'd0, b_occ}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Full-rate stream, no downstream stall: latency 4, occupancy settles at 4.
    for (int i = 0; i < 16; i++) begin
      drive_a(4'(i), 1'b0, 1'b0, cyc + 4, acc);
      if (i >= 4) check("t1_occupancy", {60'd0, a_occ}, 64'd4);
    end
    a_in_valid = 1'b0;
    repeat (8) tick();
    check("t1_drained", 64'(q_a.size()), 64'd0);
    check("t1_occ_empty", {60'd0, a_occ}, 64'd0);

    // Downstream stalled: exactly 8 tokens fit, then the stall reaches upstream.
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      drive_a(4'(accepted), 1'b1, accepted >= 8, -1, acc);
      if (acc) accepted++;
    end
    check("t2_accepted", 64'(accepted), 64'd8);
    a_in_valid = 1'b0;
    @(negedge clk);
    check("t2_occ_full", {60'd0, a_occ}, 64'd8);
    check("t2_stall_held", {63'd0, a_out_stall}, 64'd1);
    tick();
    a_in_stall = 1'b0;
    r = cyc;
    for (int i = 0; i < 8; i++) q_a[i].due = r + i;
    repeat (10) tick();
    check("t2_drained", 64'(q_a.size()), 64'd0);
    check("t2_occ_empty", {60'd0, a_occ}, 64'd0);

    // One-cycle downstream stall in a full-rate stream: bubble reaches out_stall 4 cycles later.
    s    = cyc;
    t_st = s + 8;
    k    = 0;
    while (k < 16) begin
      drive_a(4'(k), cyc == t_st, cyc == t_st + 4,
              (s + 4 + k < t_st) ? s + 4 + k : s + 5 + k, acc);
      if (acc) k++;
    end
    a_in_valid = 1'b0;
    a_in_stall = 1'b0;
    repeat (8) tick();
    check("t3_drained", 64'(q_a.size()), 64'd0);

    // Flush with six tokens held and the output stalled; the token offered on the flush edge is dropped.
    for (int i = 0; i < 6; i++) drive_a(4'(i), 1'b1, 1'b0, -1, acc);
    a_in_valid = 1'b1;
    a_id       = 4'hE;
    a_addr     = 32'h1000 + 32'hE;
    a_flush    = 1'b1;
    @(negedge clk);
    check("t4_occ_before", {60'd0, a_occ}, 64'd6);
    tick();
    a_flush = 1'b0;
    q_a.delete();
    a_in_stall = 1'b0;
    a_id       = 4'h9;
    a_addr     = 32'h1009;
    @(negedge clk);
    check("t4_occ_after", {60'd0, a_occ}, 64'd0);
    check("t4_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("t4_out_stall", {63'd0, a_out_stall}, 64'd0);
    tb.addr = 32'h1009;
    tb.id   = 4'h9;
    tb.due  = cyc + 4;
    q_a.push_back(tb);
    tick();
    a_in_valid = 1'b0;
    repeat (8) tick();
    check("t4_drained", 64'(q_a.size()), 64'd0);

    // Asynchronous reset mid-stream, then normal latency afterwards.
    for (int i = 0; i < 6; i++) drive_a(4'(i), 1'b0, 1'b0, cyc + 4, acc);
    a_in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("t5_out_stall", {63'd0, a_out_stall}, 64'd0);
    check("t5_occupancy", {60'd0, a_occ}, 64'd0);
    q_a.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    drive_a(4'h5, 1'b0, 1'b0, cyc + 4, acc);
    a_in_valid = 1'b0;
    repeat (6) tick();
    check("t5_drained", 64'(q_a.size()), 64'd0);

    // DEPTH=1: two tokens fit under stall, then latency 1.
    b_in_stall = 1'b1;
    accepted   = 0;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_id       = 4'(accepted);
      b_addr     = 32'h2000 + 32'(accepted);
      @(negedge clk);
      check("t6_out_stall", {63'd0, b_out_stall}, {63'd0, accepted >= 2});
      if (accepted < 2) begin
        tb.addr = 32'h2000 + 32'(accepted);
        tb.id   = 4'(accepted);
        tb.due  = -1;
        q_b.push_back(tb);
        accepted++;
      end
      tick();
    end
    b_in_valid = 1'b0;
    @(negedge clk);
    check("t6_occ_full", {62'd0, b_occ}, 64'd2);
    tick();
    b_in_stall = 1'b0;
    r = cyc;
    q_b[0].due = r;
    q_b[1].due = r + 1;
    repeat (3) tick();
    b_in_valid = 1'b1;
    b_id       = 4'h7;
    b_addr     = 32'h2007;
    tb.addr = 32'h2007;
    tb.id   = 4'h7;
    tb.due  = cyc + 1;
    q_b.push_back(tb);
    @(negedge clk);
    check("t6_stall_free", {63'd0, b_out_stall}, 64'd0);
    tick();
    b_in_valid = 1'b0;
    repeat (3) tick();
    check("t6_drained", 64'(q_b.size()), 64'd0);
    check("t6_occ_empty", {62'd0, b_occ}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
